// File: rtl/data_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arb_pkg
// Shared types and constants for the data memory arbiter.
//   arb_state_t : ownership FSM states (IDLE, OWN0, OWN1)
//   DEPTH_WORDS : default memory depth in 32-bit words
//   WORD_SHIFT  : byte-address to word-index shift
// -----------------------------------------------------------------------------
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int DEPTH_WORDS = 64;
    localparam int WORD_SHIFT  = 2;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker. Purely combinational.
// Ports:
//   req  in  [1:0] request vector
//   last in        index of the most recently granted requester
//   mask in  [1:0] requesters eligible this cycle (ownership from the FSM)
//   gnt  out [1:0] one-hot grant, or zero when nothing is eligible
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] elig;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        elig = req & mask;
        gnt  = elig;
        // On a tie the requester that did not win last time goes first.
        if (elig == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares a single-port data memory (combinational read, synchronous write)
// between the load/store port (requester 0) and an auxiliary master
// (requester 1). Round-robin arbitration, optional lock for multi-access
// sequences, registered read data shared by both requesters.
//
// Build option: define DATA_MEM_ARB_RANGE_CHECK_EN to flag accesses at or
// above 4*DEPTH_WORDS (write suppressed, errX pulse, no rvalidX). Without it
// the address simply wraps in the memory and err0/err1 stay low.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   req/we/lock/addr/wdata X requester X access (held until gntX)
//   gntX                     access performed this cycle (combinational)
//   rvalidX                  one-cycle pulse, rdata valid for requester X
//   rdata                    registered read data, held until next read
//   errX                     one-cycle pulse, out-of-range access
//   mem_we/mem_a/mem_wd      memory write enable, byte address, write data
//   mem_rd                   memory combinational read data
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = data_mem_arb_pkg::DEPTH_WORDS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH_WORDS << WORD_SHIFT);

    arb_state_t state;
    logic       last;
    logic [1:0] mask;
    logic [1:0] arb_gnt;
    logic [1:0] gnt;
    logic       sel;
    logic       sel_we;
    logic       sel_lock;
    logic       any_gnt;
    logic       addr_oor;
    logic       blocked;
    logic       rd_ok;
    logic [1:0] err_q;

    // Ownership restricts which requester may be arbitrated in.
    always_comb begin
        mask = 2'b11;
        case (state)
            OWN0:    mask = 2'b01;
            OWN1:    mask = 2'b10;
            default: mask = 2'b11;
        endcase
    end

    rr_arb2 u_rr_arb2 (
        .req  ({req1, req0}),
        .last (last),
        .mask (mask),
        .gnt  (arb_gnt)
    );

    // Grants are forced low during reset so no memory write can occur.
    assign gnt     = RST ? 2'b00 : arb_gnt;
    assign gnt0    = gnt[0];
    assign gnt1    = gnt[1];
    assign any_gnt = |gnt;

    // Requester 0 drives the memory port whenever requester 1 is not granted.
    assign sel      = gnt[1];
    assign mem_a    = sel ? addr1  : addr0;
    assign mem_wd   = sel ? wdata1 : wdata0;
    assign sel_we   = sel ? we1    : we0;
    assign sel_lock = sel ? lock1  : lock0;

    assign addr_oor = (mem_a >= ADDR_LIMIT);

`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
    assign blocked = any_gnt & addr_oor;
`else
    // Without the check the range flag has no consumer.
    logic unused_addr_oor;
    assign unused_addr_oor = addr_oor;
    assign blocked         = 1'b0;
`endif

    assign mem_we = any_gnt &  sel_we & ~blocked;
    assign rd_ok  = any_gnt & ~sel_we & ~blocked;

    // err_q is constant zero when the range check is not built in.
    assign err0 = err_q[0];
    assign err1 = err_q[1];

    always_ff @(posedge CLK) begin
        // NOTE: synchronous reset is sampled like any other input inside the
        // clocked block; it is not in the sensitivity list.
        if (RST) begin
            state   <= IDLE;
            last    <= 1'b1;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
            err_q   <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments for all state, so every register
            // samples pre-edge values regardless of statement order.
            rvalid0 <= rd_ok & ~sel;
            rvalid1 <= rd_ok &  sel;
            err_q   <= {blocked & sel, blocked & ~sel};
            if (rd_ok) begin
                rdata <= mem_rd;
            end
            if (any_gnt) begin
                last <= sel;
            end
            case (state)
                IDLE: begin
                    if (any_gnt && sel_lock) begin
                        state <= sel ? OWN1 : OWN0;
                    end
                end
                // The owner is the only eligible requester, so while it
                // requests it is granted; release on unlocked grant or drop.
                OWN0: begin
                    if (!req0 || (gnt[0] && !lock0)) begin
                        state <= IDLE;
                    end
                end
                OWN1: begin
                    if (!req1 || (gnt[1] && !lock1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter with a 64-word behavioural memory
// (combinational read, synchronous write). Honors DATA_MEM_ARB_RANGE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        req0, we0, lock0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1, lock1;
    logic [31:0] addr1, wdata1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata;
    logic        err0, err1;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_arbiter dut (
        .CLK     (CLK),
        .RST     (RST),
        .req0    (req0),
        .we0     (we0),
        .lock0   (lock0),
        .addr0   (addr0),
        .wdata0  (wdata0),
        .req1    (req1),
        .we1     (we1),
        .lock1   (lock1),
        .addr1   (addr1),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .err0    (err0),
        .err1    (err1),
        .mem_we  (mem_we),
        .mem_a   (mem_a),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: word index from byte address bits [7:2], so addresses wrap.
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        cycle();
        pre_we   = 1'b0;
    endtask

    task automatic idle_reqs();
        req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    initial begin
        pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        idle_reqs();
        RST = 1'b1;

        // Reset: both requesting, grants must stay low and no write occurs.
        req0 = 1'b1; we0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
        preload(6'd0, 32'h1234_5678);
        preload(6'd3, 32'hDEAD_BEEF);
        preload(6'd8, 32'hA5A5_A5A5);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err0", err0, 0);
        check("rst_err1", err1, 0);
        check("rst_mem0", mem[0], 32'h1234_5678);

        // Contention from reset: tie goes to requester 0, then requester 1.
        RST = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h14; wdata1 = 32'h22;
        #1;
        check("cont_c0_gnt0", gnt0, 1);
        check("cont_c0_gnt1", gnt1, 0);
        check("cont_c0_mem_a", mem_a, 32'h10);
        check("cont_c0_mem_we", mem_we, 1);
        cycle();
        req0 = 1'b0;
        #1;
        check("cont_c1_gnt1", gnt1, 1);
        check("cont_c1_gnt0", gnt0, 0);
        check("cont_c1_mem_a", mem_a, 32'h14);
        check("cont_c1_mem_wd", mem_wd, 32'h22);
        cycle();
        idle_reqs();
        check("cont_mem4", mem[4], 32'h11);
        check("cont_wr_no_rvalid1", rvalid1, 0);
        req0 = 1'b1; addr0 = 32'h10;
        cycle();
        idle_reqs();
        check("cont_rd0_rvalid0", rvalid0, 1);
        check("cont_rd0_rdata", rdata, 32'h11);
        req1 = 1'b1; addr1 = 32'h14;
        cycle();
        idle_reqs();
        check("cont_rd1_rvalid1", rvalid1, 1);
        check("cont_rd1_rvalid0", rvalid0, 0);
        check("cont_rd1_rdata", rdata, 32'h22);

        // Single read of word 3.
        req0 = 1'b1; addr0 = 32'h0C;
        #1;
        check("rd_gnt0", gnt0, 1);
        check("rd_mem_we", mem_we, 0);
        cycle();
        idle_reqs();
        check("rd_rvalid0", rvalid0, 1);
        check("rd_rvalid1", rvalid1, 0);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        cycle();
        check("rd_rvalid0_pulse", rvalid0, 0);
        check("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

        // Lock: requester 1 read-modify-write of 0x20 while requester 0 waits.
        req0 = 1'b1; addr0 = 32'h00;
        req1 = 1'b1; we1 = 1'b0; lock1 = 1'b1; addr1 = 32'h20;
        #1;
        check("lock_a_gnt1", gnt1, 1);
        check("lock_a_gnt0", gnt0, 0);
        cycle();
        we1 = 1'b1; lock1 = 1'b0; wdata1 = 32'h77;
        #1;
        check("lock_b_gnt1", gnt1, 1);
        check("lock_b_gnt0", gnt0, 0);
        check("lock_b_rvalid1", rvalid1, 1);
        check("lock_b_rdata", rdata, 32'hA5A5_A5A5);
        cycle();
        req1 = 1'b0; we1 = 1'b0;
        #1;
        check("lock_c_gnt0", gnt0, 1);
        check("lock_c_mem8", mem[8], 32'h77);
        cycle();
        idle_reqs();
        check("lock_c_rvalid0", rvalid0, 1);

        // Lock released by dropping req: other requester waits one more cycle.
        req0 = 1'b1; addr0 = 32'h00;
        req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h20;
        #1;
        check("drop_a_gnt1", gnt1, 1);
        cycle();
        req1 = 1'b0; lock1 = 1'b0;
        #1;
        check("drop_b_gnt0", gnt0, 0);
        cycle();
        check("drop_c_gnt0", gnt0, 1);
        cycle();
        idle_reqs();

        // Read/write ordering across requesters.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h08; wdata0 = 32'h55;
        #1;
        check("rw_wr_mem_we", mem_we, 1);
        cycle();
        idle_reqs();
        req1 = 1'b1; addr1 = 32'h08;
        #1;
        check("rw_rd_gnt1", gnt1, 1);
        cycle();
        idle_reqs();
        check("rw_rvalid1", rvalid1, 1);
        check("rw_rvalid0", rvalid0, 0);
        check("rw_rdata", rdata, 32'h55);

        // Both reading without lock: grants alternate, starting with 0.
        req0 = 1'b1; addr0 = 32'h0C;
        req1 = 1'b1; addr1 = 32'h08;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("alt%0d_gnt0", i), gnt0, (i % 2 == 0) ? 1 : 0);
            check($sformatf("alt%0d_gnt1", i), gnt1, (i % 2 == 0) ? 0 : 1);
            cycle();
        end
        idle_reqs();

        // Reset in the cycle after a read grant.
        req0 = 1'b1; addr0 = 32'h0C;
        #1;
        check("rstrd_gnt0", gnt0, 1);
        cycle();
        idle_reqs();
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        check("rstrd_rvalid0", rvalid0, 0);
        check("rstrd_rdata", rdata, 0);
        req0 = 1'b1; addr0 = 32'h0C;
        req1 = 1'b1; addr1 = 32'h08;
        #1;
        check("rstrd_tie_gnt0", gnt0, 1);
        check("rstrd_tie_gnt1", gnt1, 0);
        cycle();
        idle_reqs();
        cycle();

        // Out-of-range write to 0x100.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'hFF;
        #1;
        check("oor_gnt0", gnt0, 1);
`ifdef DATA_MEM_ARB_RANGE_CHECK_EN
        check("oor_mem_we", mem_we, 0);
        cycle();
        idle_reqs();
        check("oor_err0", err0, 1);
        check("oor_rvalid0", rvalid0, 0);
        check("oor_mem0", mem[0], 32'h1234_5678);
        cycle();
        check("oor_err0_pulse", err0, 0);
        // Out-of-range read: no rvalid, rdata untouched.
        req0 = 1'b1; addr0 = 32'h104;
        cycle();
        idle_reqs();
        check("oor_rd_err0", err0, 1);
        check("oor_rd_rvalid0", rvalid0, 0);
        check("oor_rd_rdata", rdata, 32'hDEAD_BEEF);
`else
        check("wrap_mem_we", mem_we, 1);
        cycle();
        idle_reqs();
        check("wrap_err0", err0, 0);
        check("wrap_rvalid0", rvalid0, 0);
        check("wrap_mem0", mem[0], 32'hFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-port, 64-word data memory between the processor load/store port (requester 0) and an auxiliary master such as a DMA or debug/display reader (requester 1). It selects one requester per cycle with round-robin priority and drives the memory's combinational-read/synchronous-write port. It registers read data back to the winning requester. An optional lock holds ownership across multi-access sequences such as read-modify-write.

## Interface
- DATA_W, 32, data width of both requester ports and the memory port
- ADDR_W, 32, byte-address width
- DEPTH_WORDS, 64, memory depth in 32-bit words; valid byte addresses are 0 to 4*DEPTH_WORDS-1
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request; held until the matching grant
- we0 / we1  in  1  1 = write, 0 = read; sampled with req
- lock0 / lock1  in  1  keep ownership after this access
- addr0 / addr1  in  ADDR_W  byte address; bits [1:0] ignored
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  access performed this cycle (combinational, one-hot or zero)
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data valid on rdata
- rdata  out  DATA_W  registered read data, shared by both requesters
- err0 / err1  out  1  one-cycle pulse: address out of range (see Configuration)
- mem_we  out  1  memory write enable
- mem_a  out  ADDR_W  memory byte address, the selected requester's address
- mem_wd  out  DATA_W  memory write data
- mem_rd  in  DATA_W  memory combinational read data

## Operation
- FSM states: IDLE, OWN0, OWN1. Reset state is IDLE. The round-robin pointer `last` resets to 1, so requester 0 wins the first tie.
- In IDLE with one request pending, that requester is granted.
- In IDLE with both requests pending, the requester not equal to `last` is granted. `last` updates to the granted index on every grant.
- In OWNx, only requester x can be granted. The other requester's req is ignored and must be held.
- Transitions:
  - IDLE → OWNx when x is granted with lockx=1.
  - OWNx → OWNx when x is granted with lockx=1.
  - OWNx → IDLE when x is granted with lockx=0, or when reqx=0.
  - From IDLE, a grant with lock=0 stays in IDLE.
- mem_a and mem_wd are muxed from the granted requester. With no grant, they are muxed from requester 0.
- mem_we = 1 only when a write is granted.
- Read grant: rdata <= mem_rd at the end of the grant cycle, and rvalidx pulses in the next cycle.
- Write grant: no rvalid is produced.
- Reset values: gnt0/1=0 (forced low while RST=1), rvalid0/1=0, rdata=0, err0/1=0, mem_we=0, state IDLE, last=1.

## Timing
- Grant latency: 0 cycles. The access occurs in the same cycle req is seen, if it is arbitrated in.
- Write is committed at the rising edge that ends the grant cycle.
- Read latency: 1 cycle from grant to rvalid. rdata holds its value until the next read grant.
- Throughput: one access per cycle, back-to-back reads and writes allowed. Alternating grants occur when both requesters keep requesting without lock.
- A requester denied in cycle n is granted no later than cycle n+1 in IDLE. Under lock, it is granted in the first cycle after the owner releases.
- Reset mid-operation: a pending rvalid is dropped, lock ownership is cleared, and no memory write happens in any cycle with RST=1.

## Configuration
- Macro DATA_MEM_ARB_RANGE_CHECK_EN.
- Defined:
  - A granted access with addr >= 4*DEPTH_WORDS is still granted (gnt=1) but suppresses mem_we.
  - That access pulses errx in the following cycle, produces no rvalidx, and leaves rdata unchanged.
- Undefined:
  - No check is made; the address wraps modulo DEPTH_WORDS words.
  - err0/err1 are tied to 0.

## Structure
- Package data_mem_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - DEPTH_WORDS and the word-index shift (2).
- Sub-module rr_arb2 is the 2-way round-robin picker.
  - Inputs: req vector, `last`, and a mask from the FSM ownership.
  - Output: one-hot grant.
  - The FSM, muxing, and response registers stay in data_mem_arbiter.

## Test plan
- Single read: preload word 3 = 0xDEADBEEF; req0 read addr 0x0C → gnt0 in cycle n, rvalid0 in cycle n+1 with rdata=0xDEADBEEF, rvalid1=0.
- Contention: req0 and req1 held high as writes to 0x10 (0x11) and 0x14 (0x22) from reset → gnt0 in cycle 0, gnt1 in cycle 1; reads then return 0x11 and 0x22.
- Lock: req1 read 0x20 with lock1=1, then write 0x20 with lock1=0, while req0 is held high → gnt0 stays 0 across both cycles; gnt0=1 in the next cycle.
- Read/write ordering: requester 0 writes 0x55 to 0x08 in cycle n, requester 1 reads 0x08 in cycle n+1 → rvalid1 in cycle n+2 with rdata=0x55.
- Reset mid-read: RST=1 in the cycle after a read grant → rvalid0=0 and rdata=0; after release, state is IDLE and a tie grants requester 0.
- Range (macro defined): req0 writes 0x100 with data 0xFF → gnt0=1, mem_we=0, err0 pulses in the next cycle, memory unchanged. With the macro undefined, the same write lands in word 0.
